// File: rtl/deser_pkg.sv
// Shared constants and state type for the variable-length deserializer.
package deser_pkg;

    localparam int DATA_W  = 16;
    localparam int MOD_W   = $clog2(DATA_W);
    localparam int MIN_LEN = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } deser_state_t;

endpackage

// File: rtl/deserializer_var.sv
// Serial-to-parallel stage: rebuilds MSB-first bursts framed by a valid strobe
// into a left-aligned word plus a bit count (0 encodes a full DATA_W word).
// Frames shorter than MIN_LEN are dropped and flagged on err_o.
module deserializer_var #(
    parameter int DATA_W  = deser_pkg::DATA_W,
    parameter int MIN_LEN = deser_pkg::MIN_LEN
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      data_i,
    input  logic                      data_val_i,
    output logic [DATA_W-1:0]         deser_data_o,
    output logic [$clog2(DATA_W)-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o,
    output logic                      busy_o,
    output logic                      err_o
);
    import deser_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);

    // Count value held while the last bit of a full word is being sampled.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_LEN);

    deser_state_t      state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] word_reg;
    logic [CNT_W-1:0]  mod_reg;
    logic              val_reg;
    logic              err_reg;

    logic [CNT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_next;
    logic              full_hit;

    // Insert the incoming bit at the position selected by the running count.
    // cnt_reg is 0 in IDLE, so the first bit lands in the MSB.
    always_comb begin
        bit_idx             = LAST_CNT - cnt_reg;
        shift_next          = shift_reg;
        shift_next[bit_idx] = data_i;
        full_hit            = (cnt_reg == LAST_CNT);
    end

    // Frame collection FSM with registered word/count/strobe outputs.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            word_reg  <= '0;
            mod_reg   <= '0;
            val_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            val_reg <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (data_val_i) begin
                        shift_reg <= shift_next;
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (data_val_i) begin
                        if (full_hit) begin
                            // Last bit of a full word: emit and be ready for
                            // a new first bit on the very next edge.
                            word_reg  <= shift_next;
                            mod_reg   <= '0;
                            val_reg   <= 1'b1;
                            shift_reg <= '0;
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                        end else begin
                            shift_reg <= shift_next;
                            cnt_reg   <= cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        // Gap closes a partial frame; unfilled LSBs are
                        // already zero because shift_reg is cleared on close.
                        if (cnt_reg < MIN_CNT) begin
                            err_reg <= 1'b1;
                        end else begin
                            word_reg <= shift_reg;
                            mod_reg  <= cnt_reg;
                            val_reg  <= 1'b1;
                        end
                        shift_reg <= '0;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign deser_data_o     = word_reg;
    assign deser_data_mod_o = mod_reg;
    assign deser_data_val_o = val_reg;
    assign err_o            = err_reg;
    assign busy_o           = (cnt_reg != '0);

endmodule

// File: tb/tb_deserializer_var.sv
// Self-checking bench for deserializer_var: directed scenarios plus a random
// serializer-style loopback, with a scoreboard of expected strobes.
module tb_deserializer_var;

    localparam int DW = 16;
    localparam int MW = 4;

    logic          clk;
    logic          srst;
    logic          data;
    logic          data_val;
    logic [DW-1:0] deser_data;
    logic [MW-1:0] deser_data_mod;
    logic          deser_data_val;
    logic          busy;
    logic          err;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    typedef struct {
        logic          is_err;
        logic [DW-1:0] word;
        logic [MW-1:0] mod;
    } exp_t;

    exp_t exp_q[$];

    deserializer_var dut (
        .clk_i            (clk),
        .srst_i           (srst),
        .data_i           (data),
        .data_val_i       (data_val),
        .deser_data_o     (deser_data),
        .deser_data_mod_o (deser_data_mod),
        .deser_data_val_o (deser_data_val),
        .busy_o           (busy),
        .err_o            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Scoreboard monitor: every strobe or error pulse must match the oldest
    // expected entry.
    always @(negedge clk) begin
        if (!srst && (deser_data_val || err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output val=%0b err=%0b word=%h mod=%0d required=none",
                         deser_data_val, err, deser_data, deser_data_mod);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_err) begin
                    if (!(err === 1'b1 && deser_data_val === 1'b0)) begin
                        failures++;
                        $display("FAIL sb_err val=%0b err=%0b required val=0 err=1",
                                 deser_data_val, err);
                    end
                end else begin
                    if (!(deser_data_val === 1'b1 && err === 1'b0 &&
                          deser_data === e.word && deser_data_mod === e.mod)) begin
                        failures++;
                        $display("FAIL sb_word val=%0b err=%0b word=%h mod=%0d required word=%h mod=%0d",
                                 deser_data_val, err, deser_data, deser_data_mod, e.word, e.mod);
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] top_mask(input int n);
        logic [DW-1:0] ones;
        ones = '1;
        if (n >= DW) return ones;
        return ~(ones >> n);
    endfunction

    // Drive n bits MSB first on consecutive edges, then an optional idle edge.
    // Ends 1 time unit after the last driven edge.
    task automatic send_frame(input logic [DW-1:0] word, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            data     = word[DW-1-i];
            data_val = 1'b1;
            @(posedge clk); #1;
        end
        data_val = 1'b0;
        data     = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push_expect(input logic [DW-1:0] word, input int n);
        exp_t e;
        e.is_err = (n < 3);
        e.word   = word & top_mask(n);
        e.mod    = MW'(n);
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        srst = 1'b1; data = 1'b1; data_val = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({deser_data, deser_data_mod, deser_data_val, busy, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs word=%h mod=%0d val=%0b busy=%0b err=%0b required all 0",
                     deser_data, deser_data_mod, deser_data_val, busy, err);
        end
        srst = 1'b0; data_val = 1'b0; data = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_full_word();
        push_expect(16'hA5C3, 16);
        send_frame(16'hA5C3, 16, 1'b0);
        checks++;
        if (deser_data_val !== 1'b1 || deser_data !== 16'hA5C3 || deser_data_mod !== 4'd0) begin
            failures++;
            $display("FAIL full_word_latency val=%0b word=%h mod=%0d required val=1 word=a5c3 mod=0",
                     deser_data_val, deser_data, deser_data_mod);
        end
        idle_cycles(3);
    endtask

    task automatic test_short_word();
        push_expect(16'hB000, 5);
        send_frame(16'hB000, 5, 1'b1);
        checks++;
        if (deser_data_val !== 1'b1 || deser_data !== 16'hB000 || deser_data_mod !== 4'd5) begin
            failures++;
            $display("FAIL short_word_latency val=%0b word=%h mod=%0d required val=1 word=b000 mod=5",
                     deser_data_val, deser_data, deser_data_mod);
        end
        idle_cycles(2);
    endtask

    task automatic test_short_err();
        push_expect(16'hC000, 2);
        send_frame(16'hC000, 2, 1'b1);
        checks++;
        if (err !== 1'b1 || deser_data_val !== 1'b0 ||
            deser_data !== 16'hB000 || deser_data_mod !== 4'd5) begin
            failures++;
            $display("FAIL short_err err=%0b val=%0b word=%h mod=%0d required err=1 val=0 word=b000 mod=5",
                     err, deser_data_val, deser_data, deser_data_mod);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_single_cycle err=%0b required 0", err);
        end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        int first_cyc;
        int gap_cyc;
        int busy_low;
        bit seen;
        push_expect(16'hFFFF, 16);
        push_expect(16'h0001, 16);
        busy_low = 0;
        first_cyc = -1;
        gap_cyc = -1;
        fork
            begin
                send_frame(16'hFFFF, 16, 1'b0);
                send_frame(16'h0001, 16, 1'b1);
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 60 && gap_cyc < 0; i++) begin
                    @(negedge clk);
                    if (deser_data_val === 1'b1) begin
                        if (!seen) begin
                            seen = 1'b1;
                            first_cyc = cycle;
                        end else begin
                            gap_cyc = cycle - first_cyc;
                        end
                    end else if (seen && busy !== 1'b1) begin
                        busy_low++;
                    end
                end
            end
        join
        checks++;
        if (gap_cyc != 16) begin
            failures++;
            $display("FAIL b2b_spacing cycles=%0d required 16", gap_cyc);
        end
        checks++;
        if (busy_low != 0) begin
            failures++;
            $display("FAIL b2b_busy low_cycles=%0d required 0", busy_low);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_frame();
        send_frame(16'h5A00, 7, 1'b0);
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        checks++;
        if ({deser_data, deser_data_mod, deser_data_val, busy, err} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs word=%h mod=%0d val=%0b busy=%0b err=%0b required all 0",
                     deser_data, deser_data_mod, deser_data_val, busy, err);
        end
        push_expect(16'hE000, 3);
        send_frame(16'hE000, 3, 1'b1);
        checks++;
        if (deser_data_val !== 1'b1 || deser_data !== 16'hE000 || deser_data_mod !== 4'd3) begin
            failures++;
            $display("FAIL mid_reset_frame val=%0b word=%h mod=%0d required val=1 word=e000 mod=3",
                     deser_data_val, deser_data, deser_data_mod);
        end
        idle_cycles(2);
    endtask

    task automatic test_busy();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_idle busy=%0b required 0", busy);
        end
        push_expect(16'h9000, 4);
        data = 1'b1; data_val = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_first busy=%0b required 1", busy);
        end
        send_frame(16'h2000, 3, 1'b1);
        checks++;
        if (busy !== 1'b0 || deser_data_val !== 1'b1) begin
            failures++;
            $display("FAIL busy_at_strobe busy=%0b val=%0b required busy=0 val=1", busy, deser_data_val);
        end
        idle_cycles(2);
    endtask

    task automatic test_loopback(input int frames);
        logic [DW-1:0] w;
        int mod;
        int n;
        bit gap;
        for (int k = 0; k < frames; k++) begin
            w   = DW'($urandom());
            mod = $urandom_range(0, 15);
            n   = (mod == 0) ? 16 : mod;
            gap = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            push_expect(w, n);
            send_frame(w, n, gap);
        end
        data_val = 1'b0;
        idle_cycles(3);
    endtask

    initial begin
        srst = 1'b0; data = 1'b0; data_val = 1'b0;
        test_reset();
        test_full_word();
        test_short_word();
        test_short_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_busy();
        test_loopback(2000);
        idle_cycles(4);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_outputs pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cycle=%0d required completion", cycle);
        $fatal(1, "timeout");
    end

endmodule
